// File: rtl/mul_seq_ctrl_if.sv
// EX-stage multiply sequencer handshake: run/request/flush and operands in, stall/status/product out.
// Master drives the request side (pipeline control); slave is the sequencer.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             req_i;
    logic             flush_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_hi_o;

    modport master (
        output start_i, req_i, flush_i, op_a_i, op_b_i,
        input  stall_o, busy_o, done_o, result_o, result_hi_o
    );

    modport slave (
        input  start_i, req_i, flush_i, op_a_i, op_b_i,
        output stall_o, busy_o, done_o, result_o, result_hi_o
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier: stall held 1 + WIDTH/BITS_PER_CYCLE cycles, then a one-cycle done strobe.
// start_i=0 freezes all state; flush_i aborts a BUSY operation without touching the last result.
module mul_seq_ctrl #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_EXIT     = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mul_seq_ctrl_if.slave bus
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_step, res_q;
    logic [WIDTH-1:0]     mplier_q, mplier_step;
    logic [CW-1:0]        cnt_q;
    logic                 accept, last_step, stall, done;

    always_comb begin
        acc_step = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                acc_step = acc_step + (mcand_q << k);
            end
        end
    end

    assign mplier_step = mplier_q >> BITS_PER_CYCLE;
    assign last_step   = (cnt_q == CW'(STEPS - 1)) || ((EARLY_EXIT != 0) && (mplier_step == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Nothing advances while the CPU run enable is low; reset also masks the combinational stall.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        if (!rst_i && bus.start_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_i && !bus.flush_i) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        state_d = IDLE;
                    end else begin
                        stall = 1'b1;
                        if (last_step) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else if (bus.start_i) begin
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, bus.op_a_i};
                mplier_q <= bus.op_b_i;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == BUSY && !bus.flush_i) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << BITS_PER_CYCLE;
                mplier_q <= mplier_step;
                cnt_q    <= cnt_q + CW'(1);
                // Result register only moves on completion so an abort leaves the old product visible.
                if (last_step) begin
                    res_q <= acc_step;
                end
            end
        end
    end

    assign bus.stall_o     = stall;
    assign bus.done_o      = done;
    assign bus.busy_o      = (state_q == BUSY);
    assign bus.result_o    = res_q[WIDTH-1:0];
    assign bus.result_hi_o = res_q[2*WIDTH-1:WIDTH];
endmodule
